// File: rtl/card_pkg.sv
// Shared types, LFSR constants and helper functions for the card-map generator.
package card_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP_A  = 15;
  localparam int TAP_B  = 13;
  localparam int TAP_C  = 12;
  localparam int TAP_D  = 10;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++)
      if ((1 << k) < v) r = k + 1;
    return r;
  endfunction

  // Smallest 2^k-1 that is >= i.
  function automatic logic [LFSR_W-1:0] mask(input logic [LFSR_W-1:0] i);
    logic [LFSR_W-1:0] m;
    m = '0;
    for (int k = 0; k < LFSR_W; k++)
      if (m < i) m = {m[LFSR_W-2:0], 1'b1};
    return m;
  endfunction

endpackage

// File: rtl/card_shuffle_gen_if.sv
// Controller/renderer handshake and map bus of the card-map generator.
interface card_shuffle_gen_if #(
  parameter int PAIRS = 8
);
  localparam int CARDS = 2 * PAIRS;
  localparam int SYM_W = (card_pkg::clog2(PAIRS) > 1) ? card_pkg::clog2(PAIRS) : 1;

  logic                   start;
  logic                   seed_load;
  logic [15:0]            seed_in;
  logic                   busy;
  logic                   done;
  logic                   map_valid;
  logic [CARDS*SYM_W-1:0] map;

  modport master (
    output start, seed_load, seed_in,
    input  busy, done, map_valid, map
  );

  modport slave (
    input  start, seed_load, seed_in,
    output busy, done, map_valid, map
  );

endinterface

// File: rtl/card_shuffle_gen_lfsr.sv
// 16-bit Fibonacci LFSR (shift left) with synchronous parallel load.
module lfsr16_load
  import card_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INITIAL_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] seed
);

  logic [LFSR_W-1:0] s_q, s_d;
  logic              fb;

  always_comb begin
    fb  = s_q[TAP_A] ^ s_q[TAP_B] ^ s_q[TAP_C] ^ s_q[TAP_D];
    s_d = load ? load_val : {s_q[LFSR_W-2:0], fb};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) s_q <= INITIAL_SEED;
    else         s_q <= s_d;
  end

  assign seed = s_q;

endmodule

// File: rtl/card_shuffle_gen.sv
// Card-map generator: in-place Fisher-Yates over 2*PAIRS slots, one swap per cycle,
// each symbol 0..PAIRS-1 appearing exactly twice in the published map.
module card_shuffle_gen
  import card_pkg::*;
#(
  parameter int          PAIRS = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter bit          FAST  = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  card_shuffle_gen_if.slave  bus
);

  localparam int CARDS = 2 * PAIRS;
  localparam int SYM_W = (clog2(PAIRS) > 1) ? clog2(PAIRS) : 1;
  localparam int IDX_W = clog2(CARDS);

  state_e                      st_q, st_d;
  logic [IDX_W-1:0]            i_q, i_d;
  logic [CARDS-1:0][SYM_W-1:0] work_q, work_d;
  logic [CARDS-1:0][SYM_W-1:0] map_q, map_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        vld_q, vld_d;

  logic [LFSR_W-1:0]           lfsr;
  logic                        ld;
  logic [LFSR_W-1:0]           ld_val;
  logic [IDX_W-1:0]            msk, r, j;
  logic                        unused_lfsr;

  assign ld          = bus.seed_load && (st_q == IDLE);
  assign ld_val      = (bus.seed_in == '0) ? SEED : bus.seed_in;
  assign unused_lfsr = ^lfsr[LFSR_W-1:IDX_W];

  lfsr16_load #(.INITIAL_SEED(SEED)) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ld),
    .load_val (ld_val),
    .seed     (lfsr)
  );

  // Fold an out-of-range draw back into 0..i; only used when FAST is set.
  always_comb begin
    msk = IDX_W'(mask(LFSR_W'(i_q)));
    r   = lfsr[IDX_W-1:0] & msk;
    j   = (r <= i_q) ? r : (r - i_q - IDX_W'(1));
  end

  always_comb begin
    st_d   = st_q;
    i_d    = i_q;
    work_d = work_q;
    map_d  = map_q;
    busy_d = busy_q;
    done_d = 1'b0;
    vld_d  = vld_q;
    unique case (st_q)
      IDLE: begin
        if (bus.start && !bus.seed_load) begin
          st_d   = INIT;
          busy_d = 1'b1;
        end
      end
      INIT: begin
        for (int s = 0; s < CARDS; s++) work_d[s] = SYM_W'(s >> 1);
        i_d  = IDX_W'(CARDS - 1);
        st_d = SHUFFLE;
      end
      SHUFFLE: begin
        if ((r <= i_q) || FAST) begin
          work_d[i_q] = work_q[j];
          work_d[j]   = work_q[i_q];
          i_d         = i_q - IDX_W'(1);
          if (i_q == IDX_W'(1)) st_d = DONE;
        end
      end
      DONE: begin
        map_d  = work_q;
        done_d = 1'b1;
        vld_d  = 1'b1;
        busy_d = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= IDLE;
      i_q    <= '0;
      work_q <= '0;
      map_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      i_q    <= i_d;
      work_q <= work_d;
      map_q  <= map_d;
      busy_q <= busy_d;
      done_q <= done_d;
      vld_q  <= vld_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.map_valid = vld_q;
  assign bus.map       = map_q;

endmodule

// File: tb/tb_card_shuffle_gen.sv
// Bench for card_shuffle_gen: four configurations run side by side against a
// Fisher-Yates reference model that predicts each map and its completion cycle.
module tb_card_shuffle_gen;

  localparam int          NI   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  function automatic int cfg_pairs(input int g);
    return (g == 0) ? 8 : (g == 1) ? 5 : (g == 2) ? 2 : 128;
  endfunction

  function automatic bit cfg_fast(input int g);
    return (g != 1);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] resetn_a, start_a, seed_load_a;
  logic [15:0]   seed_in_a [NI];
  logic [NI-1:0] done_a, busy_a, valid_a, mzero_a;
  logic [NI-1:0] e_busy_a, e_done_a, e_vld_a, map_ok_a;
  int            ms_bad_a [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // l0 is the LFSR value in the cycle start is accepted; the first draw
  // happens two LFSR steps later (after the INIT cycle).
  function automatic void predict(input logic [15:0] l0, input int cards, input int symw,
                                  input bit fast, output int nd, output logic [2047:0] pm);
    int w [256];
    int i, r, j, t, msk;
    logic [15:0] l;
    for (int s = 0; s < cards; s++) w[s] = s / 2;
    l  = lstep(lstep(l0));
    i  = cards - 1;
    nd = 0;
    while (i > 0 && nd < 200000) begin
      msk = 1;
      while (msk < i) msk = 2 * msk + 1;
      r = int'(l) & msk;
      j = -1;
      if (r <= i)    j = r;
      else if (fast) j = r - (i + 1);
      if (j >= 0) begin
        t = w[i]; w[i] = w[j]; w[j] = t;
        i--;
      end
      nd++;
      l = lstep(l);
    end
    pm = '0;
    for (int s = 0; s < cards; s++) pm = pm | (2048'(w[s]) << (s * symw));
  endfunction

  function automatic int ms_bad(input logic [2047:0] m, input int p, input int sw);
    int h [128];
    int v, bad;
    bad = 0;
    for (int k = 0; k < p; k++) h[k] = 0;
    for (int s = 0; s < 2 * p; s++) begin
      v = 0;
      for (int b = 0; b < sw; b++) v = v | (int'(m[s*sw+b]) << b);
      if (v >= p) bad++;
      else        h[v]++;
    end
    for (int k = 0; k < p; k++) if (h[k] != 2) bad++;
    return bad;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int P     = cfg_pairs(g);
    localparam bit F     = cfg_fast(g);
    localparam int CARDS = 2 * P;
    localparam int SYM_W = ($clog2(P) > 1) ? $clog2(P) : 1;
    localparam int MW    = CARDS * SYM_W;

    card_shuffle_gen_if #(.PAIRS(P)) bus ();

    card_shuffle_gen #(.PAIRS(P), .SEED(SEED), .FAST(F)) dut (
      .clk    (clk),
      .resetn (resetn_a[g]),
      .bus    (bus.slave)
    );

    assign bus.start     = start_a[g];
    assign bus.seed_load = seed_load_a[g];
    assign bus.seed_in   = seed_in_a[g];
    assign done_a[g]     = bus.done;
    assign busy_a[g]     = bus.busy;
    assign valid_a[g]    = bus.map_valid;
    assign mzero_a[g]    = (bus.map == '0);
    assign ms_bad_a[g]   = ms_bad(2048'(bus.map), P, SYM_W);

    logic [15:0]   m_lfsr;
    int            m_cnt, nd;
    logic          m_done, m_vld;
    logic [MW-1:0] m_map, m_pend;
    logic [2047:0] pm;

    initial begin
      m_lfsr = SEED; m_cnt = 0; m_done = 1'b0; m_vld = 1'b0; m_map = '0; m_pend = '0;
      forever begin
        @(posedge clk or negedge resetn_a[g]);
        if (!resetn_a[g]) begin
          m_lfsr = SEED; m_cnt = 0; m_done = 1'b0; m_vld = 1'b0; m_map = '0;
        end else begin
          m_done = 1'b0;
          if (m_cnt > 0) begin
            m_lfsr = lstep(m_lfsr);
            m_cnt--;
            if (m_cnt == 0) begin
              m_map = m_pend; m_done = 1'b1; m_vld = 1'b1;
            end
          end else if (seed_load_a[g]) begin
            m_lfsr = (seed_in_a[g] == 16'h0) ? SEED : seed_in_a[g];
          end else begin
            if (start_a[g]) begin
              predict(m_lfsr, CARDS, SYM_W, F, nd, pm);
              m_pend = MW'(pm);
              m_cnt  = nd + 2;
            end
            m_lfsr = lstep(m_lfsr);
          end
        end
      end
    end

    assign e_busy_a[g] = (m_cnt > 0);
    assign e_done_a[g] = m_done;
    assign e_vld_a[g]  = m_vld;
    assign map_ok_a[g] = (bus.map === m_map);

    bit cov [CARDS][P];
    int miss = CARDS * P;
    int v;
    initial forever begin
      @(negedge clk);
      if (bus.done === 1'b1)
        for (int s = 0; s < CARDS; s++) begin
          v = int'(bus.map[s*SYM_W +: SYM_W]);
          if (v < P && !cov[s][v]) begin
            cov[s][v] = 1'b1;
            miss--;
          end
        end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("g%0d busy", g), busy_a[g], e_busy_a[g]);
      chk($sformatf("g%0d done", g), done_a[g], e_done_a[g]);
      chk($sformatf("g%0d map_valid", g), valid_a[g], e_vld_a[g]);
      chk($sformatf("g%0d map", g), map_ok_a[g], 1);
      if (done_a[g]) chk($sformatf("g%0d multiset", g), ms_bad_a[g], 0);
    end
  end

  task automatic pulse_reset(input int g);
    @(posedge clk); #3 resetn_a[g] = 1'b0;
    @(posedge clk); #3 resetn_a[g] = 1'b1;
  endtask

  task automatic run_one(input int g, input bit do_seed, input logic [15:0] sd, input int gap,
                         input bit busy_seed, input bit both, output int lat);
    int bc;
    bit fin;
    if (both) begin
      @(posedge clk); #1 seed_load_a[g] = 1'b1; seed_in_a[g] = 16'($urandom); start_a[g] = 1'b1;
      @(posedge clk); #1 seed_load_a[g] = 1'b0; start_a[g] = 1'b0;
    end
    if (do_seed) begin
      @(posedge clk); #1 seed_load_a[g] = 1'b1; seed_in_a[g] = sd;
      @(posedge clk); #1 seed_load_a[g] = 1'b0;
    end
    repeat (gap) @(posedge clk);
    @(posedge clk); #1 start_a[g] = 1'b1;
    @(posedge clk); #1 start_a[g] = 1'b0;
    bc  = busy_a[g] ? 1 : 0;
    lat = 0;
    fin = 1'b0;
    while (!fin && lat < 5000) begin
      @(posedge clk); #1 lat++;
      if (done_a[g]) fin = 1'b1;
      if (busy_a[g]) bc++;
      if (busy_seed && lat == 4) begin
        seed_load_a[g] = 1'b1; seed_in_a[g] = 16'($urandom);
      end else seed_load_a[g] = 1'b0;
    end
    seed_load_a[g] = 1'b0;
    chk($sformatf("g%0d done_timeout", g), fin, 1);
    chk($sformatf("g%0d busy_len", g), bc, lat);
    if (cfg_fast(g)) chk($sformatf("g%0d latency", g), lat, 2 * cfg_pairs(g) + 1);
    else             chk($sformatf("g%0d latency_min", g), lat >= 2 * cfg_pairs(g) + 1, 1);
  endtask

  task automatic run_random(input int g, input int n);
    int lat;
    for (int k = 0; k < n; k++)
      run_one(g, $urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 4),
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, lat);
  endtask

  task automatic directed();
    int lat, n, w;
    run_one(0, 1'b0, 16'h0, 0, 1'b0, 1'b0, lat);
    for (int k = 0; k < 2; k++) begin
      pulse_reset(0);
      run_one(0, 1'b1, 16'h1234, 3, 1'b0, 1'b0, lat);
    end
    pulse_reset(0);
    run_one(0, 1'b1, 16'h0000, 3, 1'b0, 1'b0, lat);
    pulse_reset(0);
    run_one(0, 1'b1, SEED, 3, 1'b0, 1'b0, lat);

    // start held for 40 cycles: only back-to-back accepts, nothing queued
    @(posedge clk); #1 start_a[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1 if (done_a[0]) n++;
      if (c == 39) start_a[0] = 1'b0;
    end
    chk("g0 dones_in_40", n, 2);
    w = 0;
    while (busy_a[0] && w < 100) begin
      @(posedge clk); #1 w++;
    end
    chk("g0 drain", busy_a[0], 0);

    run_one(0, 1'b1, 16'h5A5A, 2, 1'b1, 1'b0, lat);
    run_one(0, 1'b1, 16'h5A5A, 2, 1'b0, 1'b1, lat);

    // reset in the middle of a shuffle
    @(posedge clk); #1 start_a[0] = 1'b1;
    @(posedge clk); #1 start_a[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("g0 valid_before_rst", valid_a[0], 1);
    #2 resetn_a[0] = 1'b0;
    #1;
    chk("g0 rst_busy", busy_a[0], 0);
    chk("g0 rst_done", done_a[0], 0);
    chk("g0 rst_valid", valid_a[0], 0);
    chk("g0 rst_map_zero", mzero_a[0], 1);
    @(posedge clk); #3 resetn_a[0] = 1'b1;
    run_one(0, 1'b0, 16'h0, 0, 1'b0, 1'b0, lat);

    run_random(0, 30);
  endtask

  initial begin
    resetn_a    = '0;
    start_a     = '0;
    seed_load_a = '0;
    for (int g = 0; g < NI; g++) seed_in_a[g] = 16'h0;
    repeat (3) @(posedge clk);
    #3;
    chk("g0 reset_busy", busy_a[0], 0);
    chk("g0 reset_done", done_a[0], 0);
    chk("g0 reset_valid", valid_a[0], 0);
    chk("g0 reset_map_zero", mzero_a[0], 1);
    resetn_a = '1;
    fork
      directed();
      run_random(1, 200);
      run_random(2, 40);
      run_random(3, 8);
    join
    chk("g1 slot_symbol_coverage_missing", gi[1].miss, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
